// File: rtl/rst_sync_seq.sv
// Reset generator: board reset is asserted asynchronously and released synchronously,
// then stretched, then released to NUM_OUT downstream reset domains one at a time.
module rst_sync_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_OUT        = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int DW             = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               seq_done,
  input  logic [DW-1:0]      d,
  output logic [DW-1:0]      dout
);

  localparam int CNT_MAX = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {STRETCH, RELEASE, DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   rst_sync;
  logic                   last_rel;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NUM_OUT-1:0]     rel_next;

  // Stage 0: synchroniser chain, cleared straight from the board reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p <= '0;
    else        sync_p <= {sync_p[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_p[SYNC_STAGES-1];

  // Outputs form a thermometer code, so the next release just shifts in another one
  assign rel_next = (rst_n_out << 1) | NUM_OUT'(1);

  // Stage 1: stretch / ordered-release sequencer
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= STRETCH;
      cnt       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else if (sw_rst) begin
      state     <= STRETCH;
      cnt       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      case (state)
        STRETCH, RELEASE: begin
          if (cnt == ((state == STRETCH) ? STRETCH_LAST : GAP_LAST)) begin
            cnt       <= '0;
            rst_n_out <= rel_next;
            if (rel_next[NUM_OUT-1]) begin
              state    <= DONE;
              seq_done <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state     <= STRETCH;
          cnt       <= '0;
          rst_n_out <= '0;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

  assign last_rel = rst_n_out[NUM_OUT-1];

  // Stage 2: data register held clear until the last domain is out of reset
  always_ff @(posedge clk or negedge last_rel) begin
    if (!last_rel) dout <= '0;
    else           dout <= d;
  end

endmodule
